// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and segment patterns for the panel seven-segment scan logic.
package seg_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg_t;  // {a,b,c,d,e,f,g}, bit 6 = a

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  localparam seg_t SEG_0     = 7'b1111110;
  localparam seg_t SEG_1     = 7'b0110000;
  localparam seg_t SEG_2     = 7'b1101101;
  localparam seg_t SEG_3     = 7'b1111001;
  localparam seg_t SEG_4     = 7'b0110011;
  localparam seg_t SEG_5     = 7'b1011011;
  localparam seg_t SEG_6     = 7'b1011111;
  localparam seg_t SEG_7     = 7'b1110000;
  localparam seg_t SEG_8     = 7'b1111111;
  localparam seg_t SEG_9     = 7'b1111011;
  localparam seg_t SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load port and display bus of seg_scan_ctrl; flash input exists only with SEG_SCAN_FLASH_EN.
interface seg_scan_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digit_val;
  logic [NUM_DIGITS-1:0]   digit_en;
`ifdef SEG_SCAN_FLASH_EN
  logic                    flash;
`endif
  logic                    pending;
  logic                    frame_done;
  logic [NUM_DIGITS-1:0]   sm_bit;
  seg_t                    sm_seg;

`ifdef SEG_SCAN_FLASH_EN
  modport master (output load, digit_val, digit_en, flash,
                  input  pending, frame_done, sm_bit, sm_seg);
  modport slave  (input  load, digit_val, digit_en, flash,
                  output pending, frame_done, sm_bit, sm_seg);
`else
  modport master (output load, digit_val, digit_en,
                  input  pending, frame_done, sm_bit, sm_seg);
  modport slave  (input  load, digit_val, digit_en,
                  output pending, frame_done, sm_bit, sm_seg);
`endif
endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational BCD to seven-segment decoder; codes 10-15 decode to all-off.
module seg_decode
  import seg_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin seven-segment scan with blanking guard and frame-synchronous load.
// Optional blink support is enabled by defining SEG_SCAN_FLASH_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 8,
  parameter int FLASH_FRAMES = 32
)(
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.slave bus
);
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || SCAN_DIV < 1 || BLANK_CYCLES < 1 ||
      FLASH_FRAMES < 1) begin : g_bad_param
    $error("seg_scan_ctrl: parameter out of range");
  end

  scan_state_t             state;
  logic [IDX_W-1:0]        idx;
  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] stage_val, act_val;
  logic [NUM_DIGITS-1:0]   stage_en, act_en;
  logic                    pending_q, frame_done_q;
  logic [NUM_DIGITS-1:0]   sm_bit_q;
  seg_t                    sm_seg_q;

  logic blank_last, show_last, idx_last, boundary, lit;
  bcd_t cur_val;
  seg_t cur_seg;

  assign blank_last = (cnt == CNT_W'(BLANK_CYCLES - 1));
  assign show_last  = (cnt == CNT_W'(SCAN_DIV - 1));
  assign idx_last   = (idx == IDX_W'(NUM_DIGITS - 1));
  assign boundary   = (state == ST_SHOW) && show_last && idx_last;
  assign cur_val    = act_val[{idx, 2'b00} +: 4];

  seg_decode u_decode (
    .bcd (cur_val),
    .seg (cur_seg)
  );

`ifdef SEG_SCAN_FLASH_EN
  localparam int FL_W = $clog2(FLASH_FRAMES + 1);
  logic [FL_W-1:0] frame_cnt;
  logic            phase_dark;

  assign lit = (state == ST_SHOW) && act_en[idx] && !(bus.flash && phase_dark);

  always_ff @(posedge clk) begin
    if (rst || !bus.flash) begin
      frame_cnt  <= '0;
      phase_dark <= 1'b0;
    end else if (boundary) begin
      if (frame_cnt == FL_W'(FLASH_FRAMES - 1)) begin
        frame_cnt  <= '0;
        phase_dark <= ~phase_dark;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  assign lit = (state == ST_SHOW) && act_en[idx];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_BLANK;
      idx          <= '0;
      cnt          <= '0;
      stage_val    <= '1;
      stage_en     <= '0;
      act_val      <= '1;
      act_en       <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      sm_bit_q     <= '0;
      sm_seg_q     <= '0;
    end else begin
      frame_done_q <= boundary;
      sm_bit_q     <= lit ? (NUM_DIGITS'(1) << idx) : '0;
      sm_seg_q     <= lit ? cur_seg : '0;

      case (state)
        ST_BLANK: begin
          if (blank_last) begin
            cnt   <= '0;
            state <= ST_SHOW;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (show_last) begin
            cnt   <= '0;
            state <= ST_BLANK;
            idx   <= idx_last ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_BLANK;
      endcase

      // A load on the boundary cycle still promotes the previous staging (old value read here).
      if (boundary && pending_q) begin
        act_val <= stage_val;
        act_en  <= stage_en;
      end
      if (bus.load) begin
        stage_val <= bus.digit_val;
        stage_en  <= bus.digit_en;
        pending_q <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sm_bit     = sm_bit_q;
  assign bus.sm_seg     = sm_seg_q;
endmodule
